// File: rtl/matmul_seq.sv
// Operand/result sequencer for the 2x2 systolic matmul array: loads A and B as a byte
// stream, feeds skewed rows/columns into the array, captures C and streams it back out.
module matmul_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        mm_start,
  output logic [7:0]  mm_a1,
  output logic [7:0]  mm_a2,
  output logic [7:0]  mm_b1,
  output logic [7:0]  mm_b2,
  input  logic [15:0] mm_out1,
  input  logic [15:0] mm_out2,
  input  logic [15:0] mm_out3,
  input  logic [15:0] mm_out4
);

  localparam logic [2:0] S_LOAD  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_F0    = 3'd2;
  localparam logic [2:0] S_F1    = 3'd3;
  localparam logic [2:0] S_F2    = 3'd4;
  localparam logic [2:0] S_F3    = 3'd5;
  localparam logic [2:0] S_CAP   = 3'd6;
  localparam logic [2:0] S_SEND  = 3'd7;

  logic [2:0]      r_state;
  logic [2:0]      w_state_d;
  logic [2:0]      r_cnt;
  logic [2:0]      r_scnt;
  // Slots 0..7: a11, a12, a21, a22, b11, b12, b21, b22
  logic [7:0][7:0] r_op;
  // Bytes 0..7: C11 lo/hi, C12 lo/hi, C21 lo/hi, C22 lo/hi
  logic [7:0][7:0] r_res;

  logic w_load_hs;
  logic w_send_hs;

  assign in_ready  = (r_state == S_LOAD);
  assign busy      = (r_state != S_LOAD);
  assign out_valid = (r_state == S_SEND);
  assign out_data  = (r_state == S_SEND) ? r_res[r_scnt] : 8'd0;

  assign w_load_hs = in_valid && in_ready;
  assign w_send_hs = out_valid && out_ready;

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      S_LOAD:  if (w_load_hs && (r_cnt == 3'd7)) w_state_d = S_START;
      S_START: w_state_d = S_F0;
      S_F0:    w_state_d = S_F1;
      S_F1:    w_state_d = S_F2;
      S_F2:    w_state_d = S_F3;
      S_F3:    w_state_d = S_CAP;
      S_CAP:   w_state_d = S_SEND;
      S_SEND:  if (w_send_hs && (r_scnt == 3'd7)) w_state_d = S_LOAD;
      default: w_state_d = S_LOAD;
    endcase
  end

  // Skewed feed: row 2 / column 2 lag row 1 / column 1 by one cycle.
  always_comb begin
    mm_start = 1'b0;
    mm_a1    = 8'd0;
    mm_b1    = 8'd0;
    mm_a2    = 8'd0;
    mm_b2    = 8'd0;
    case (r_state)
      S_START: mm_start = 1'b1;
      S_F0: begin
        mm_a1 = r_op[0];
        mm_b1 = r_op[4];
      end
      S_F1: begin
        mm_a1 = r_op[1];
        mm_b1 = r_op[6];
        mm_a2 = r_op[2];
        mm_b2 = r_op[5];
      end
      S_F2: begin
        mm_a2 = r_op[3];
        mm_b2 = r_op[7];
      end
      default: ;
    endcase
  end

  // Both counters are 3 bits and wrap to 0 after the eighth byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_LOAD;
      r_cnt   <= 3'd0;
      r_scnt  <= 3'd0;
      r_op    <= '0;
      r_res   <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_load_hs) begin
        r_op[r_cnt] <= in_data;
        r_cnt       <= r_cnt + 3'd1;
      end
      if (r_state == S_CAP) begin
        r_res <= {mm_out4, mm_out3, mm_out2, mm_out1};
      end
      if (w_send_hs) begin
        r_scnt <= r_scnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_matmul_seq.sv
// Directed bench for matmul_seq with a behavioural 2x2 systolic array attached.
module tb_matmul_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        mm_start;
  logic [7:0]  mm_a1, mm_a2, mm_b1, mm_b2;
  logic [15:0] acc11 = 16'd0, acc12 = 16'd0, acc21 = 16'd0, acc22 = 16'd0;
  logic [7:0]  ra11 = 8'd0, rb11 = 8'd0, ra21 = 8'd0, rb12 = 8'd0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  matmul_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .mm_start  (mm_start),
    .mm_a1     (mm_a1),
    .mm_a2     (mm_a2),
    .mm_b1     (mm_b1),
    .mm_b2     (mm_b2),
    .mm_out1   (acc11),
    .mm_out2   (acc12),
    .mm_out3   (acc21),
    .mm_out4   (acc22)
  );

  // 2x2 systolic array: A moves right, B moves down, start clears everything.
  always @(posedge clk) begin
    if (mm_start) begin
      acc11 <= 16'd0; acc12 <= 16'd0; acc21 <= 16'd0; acc22 <= 16'd0;
      ra11 <= 8'd0; rb11 <= 8'd0; ra21 <= 8'd0; rb12 <= 8'd0;
    end else begin
      acc11 <= acc11 + {8'd0, mm_a1} * {8'd0, mm_b1};
      acc12 <= acc12 + {8'd0, ra11} * {8'd0, mm_b2};
      acc21 <= acc21 + {8'd0, mm_a2} * {8'd0, rb11};
      acc22 <= acc22 + {8'd0, ra21} * {8'd0, rb12};
      ra11 <= mm_a1;
      rb11 <= mm_b1;
      ra21 <= mm_a2;
      rb12 <= mm_b2;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ops(input string name, input logic [63:0] ops, input int max_gap);
    int g;
    for (int i = 0; i < 8; i++) begin
      g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      in_valid = 1'b0;
      repeat (g) tick();
      in_valid = 1'b1;
      in_data  = ops[i*8 +: 8];
      check({name, "/ld_ready"}, 32'(in_ready), 1);
      tick();
    end
  endtask

  // Ops packed {b22,b21,b12,b11,a22,a21,a12,a11}; exp packed C22hi..C11lo.
  task automatic run_job(input string name, input logic [63:0] ops, input logic [63:0] exp,
                         input int max_gap, input int stall, input bit chk_stream,
                         input bit hold_aa);
    logic [31:0] st [0:5];
    int          starts;
    int          w;
    logic [7:0]  held;
    st[0] = 32'h0000_0000;
    st[1] = 32'h0105_0000;
    st[2] = 32'h0207_0306;
    st[3] = 32'h0000_0408;
    st[4] = 32'h0000_0000;
    st[5] = 32'h0000_0000;
    starts = 0;
    load_ops(name, ops, max_gap);
    in_valid = hold_aa;
    in_data  = hold_aa ? 8'hAA : 8'h00;
    for (int c = 0; c < 6; c++) begin
      if (chk_stream) begin
        check({name, "/stream"}, 32'({mm_a1, mm_b1, mm_a2, mm_b2}), st[c]);
        starts += int'(mm_start);
      end
      check({name, "/early_valid"}, 32'(out_valid), 0);
      check({name, "/busy"}, 32'(busy), 1);
      if (c == 5) check({name, "/cap_ready"}, 32'(in_ready), 0);
      tick();
    end
    if (chk_stream) check({name, "/start_cycles"}, 32'(starts), 1);
    check({name, "/latency"}, 32'(out_valid), 1);
    for (int b = 0; b < 8; b++) begin
      w = 0;
      while (!out_valid && w < 20) begin
        tick();
        w++;
      end
      check({name, "/out_valid"}, 32'(out_valid), 1);
      held = out_data;
      for (int s = 0; s < stall; s++) begin
        tick();
        check({name, "/stall_data"}, 32'(out_data), 32'(held));
        check({name, "/stall_valid"}, 32'(out_valid), 1);
      end
      out_ready = 1'b1;
      check({name, "/byte"}, 32'(out_data), 32'(exp[b*8 +: 8]));
      tick();
      out_ready = 1'b0;
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
    check({name, "/end_ready"}, 32'(in_ready), 1);
    check({name, "/end_busy"}, 32'(busy), 0);
    check({name, "/end_valid"}, 32'(out_valid), 0);
  endtask

  localparam logic [63:0] OpsIdent = 64'h01_00_00_01_04_03_02_01;
  localparam logic [63:0] OpsGen   = 64'h08_07_06_05_04_03_02_01;
  localparam logic [63:0] OpsOvf   = 64'hFF_FF_FF_FF_FF_FF_FF_FF;
  localparam logic [63:0] ExpIdent = 64'h00_04_00_03_00_02_00_01;
  localparam logic [63:0] ExpGen   = 64'h00_32_00_2B_00_16_00_13;
  localparam logic [63:0] ExpOvf   = 64'hFC_02_FC_02_FC_02_FC_02;

  initial begin
    repeat (2) tick();
    check("rst/in_ready", 32'(in_ready), 1);
    check("rst/busy", 32'(busy), 0);
    check("rst/out_valid", 32'(out_valid), 0);
    check("rst/out_data", 32'(out_data), 0);
    check("rst/mm", 32'({mm_start, mm_a1, mm_b1, mm_a2, mm_b2}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_job("ident", OpsIdent, ExpIdent, 0, 0, 1'b0, 1'b0);
    run_job("general", OpsGen, ExpGen, 0, 0, 1'b1, 1'b0);
    run_job("overflow", OpsOvf, ExpOvf, 0, 0, 1'b0, 1'b0);
    run_job("stall", OpsGen, ExpGen, 3, 5, 1'b0, 1'b0);

    // Abort a job in F2 with an asynchronous reset.
    load_ops("midrst", OpsGen, 0);
    in_valid = 1'b0;
    repeat (3) tick();
    check("midrst/in_f2", 32'({mm_a2, mm_b2}), 32'h0408);
    rst_n = 1'b0;
    #1;
    check("midrst/in_ready", 32'(in_ready), 1);
    check("midrst/busy", 32'(busy), 0);
    check("midrst/out_valid", 32'(out_valid), 0);
    check("midrst/mm", 32'({mm_start, mm_a1, mm_b1, mm_a2, mm_b2}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_job("after_rst", OpsGen, ExpGen, 0, 0, 1'b0, 1'b0);

    run_job("hold_aa", OpsGen, ExpGen, 0, 2, 1'b0, 1'b1);
    run_job("b2b", OpsIdent, ExpIdent, 0, 0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
